// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared register-file constants for decode, ALU and the
// register file itself.
//   RF_DATA_W : default register width
//   RF_ADDR_W : default register index width (depth = 2**RF_ADDR_W)
//   REG_ZERO  : index of the hardwired-zero register
package mips_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register outstanding-write counters.
//   clk, rst       : clock, asynchronous active-low reset
//   iss_en, iss_rd : an instruction with destination iss_rd issues
//   wen, waddr     : writeback retires one producer of waddr
//   flush          : drop every outstanding producer
//   cnt            : outstanding producers per register (index 0 always 0)
//   err            : sticky counter overflow flag
module rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              iss_en,
    input  logic [ADDR_W-1:0]                 iss_rd,
    input  logic                              wen,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic                              flush,
    output logic [2**ADDR_W-1:0][CNT_W-1:0]   cnt,
    output logic                              err
);

    localparam int               DEPTH   = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0][CNT_W-1:0] r_cnt;
    logic                        r_err;
    logic [DEPTH-1:0]            w_inc;
    logic [DEPTH-1:0]            w_dec;
    logic [DEPTH-1:0]            w_ovf;

    // Register 0 never sees inc/dec, so its counter stays at its reset value.
    // A writeback to an idle register is an untracked write: no decrement.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_ovf = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (r != REG_ZERO) begin
                w_inc[r] = iss_en && (iss_rd == ADDR_W'(r));
                w_dec[r] = wen && (waddr == ADDR_W'(r)) && (r_cnt[r] != '0);
                w_ovf[r] = !flush && w_inc[r] && !w_dec[r] && (r_cnt[r] == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (flush)
                    r_cnt[r] <= CNT_W'(w_inc[r]);   // issue in the flush cycle survives
                else if (w_inc[r] && !w_dec[r]) begin
                    if (r_cnt[r] != CNT_MAX)
                        r_cnt[r] <= r_cnt[r] + 1'b1; // saturate on overflow
                end else if (w_dec[r] && !w_inc[r])
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err <= 1'b0;
        else if (|w_ovf)
            r_err <= 1'b1;
    end

    assign cnt = r_cnt;
    assign err = r_err;

endmodule

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: MIPS register file with write bypass, hardwired-zero r0,
// NUM_RD read ports and an outstanding-write scoreboard for RAW stalls.
//   clk, rst          : clock, asynchronous active-low reset
//   raddr/rdata       : packed read ports, port i at [i*W +: W]
//   rbusy             : per-port "operand still has a pending producer"
//   wen/waddr/wdata   : writeback
//   iss_en/iss_rd     : destination of the instruction issuing this cycle
//   flush             : discard all outstanding producers
//   err               : sticky scoreboard overflow
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       wen,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_rd,
    input  logic                       flush,
    output logic                       err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DEPTH-1:0][CNT_W-1:0]  w_cnt;
    logic                         w_wr;

    // Writes to r0 are dropped, so r_mem[0] keeps its reset value of zero.
    assign w_wr = wen && (waddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_mem <= '0;
        else if (w_wr)
            r_mem[waddr] <= wdata;
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .wen    (wen),
        .waddr  (waddr),
        .flush  (flush),
        .cnt    (w_cnt),
        .err    (err)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;

        assign w_ra  = raddr[i*ADDR_W +: ADDR_W];
        assign w_hit = w_wr && (waddr == w_ra);
        assign rdata[i*DATA_W +: DATA_W] = w_hit ? wdata : r_mem[w_ra];
        // The producer retiring this cycle is already satisfied by the bypass.
        assign rbusy[i] = w_cnt[w_ra] > CNT_W'(w_hit);
    end

endmodule

// File: tb/tb_mips_regfile_sb.sv
module tb_mips_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int CW    = 2;
    localparam int DEPTH = 32;
    localparam int CMAX  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              iss_en;
    logic [AW-1:0]     iss_rd;
    logic              flush;
    logic              err;

    always #5 clk = ~clk;

    mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_rd(iss_rd), .flush(flush), .err(err)
    );

    // reference model: architectural values and producer counts
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt [DEPTH];
    bit            m_err;

    typedef struct {
        logic [DW-1:0] rd [NR];
        logic          busy [NR];
        logic          er;
        string         tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 0;
    endtask

    // expected outputs for the inputs currently driven
    task automatic expect_now(input string tag);
        exp_t e;
        for (int p = 0; p < NR; p++) begin
            int a;
            bit fwd;
            a   = int'(raddr[p*AW +: AW]);
            fwd = wen && (int'(waddr) == a) && (a != 0);
            e.rd[p]   = fwd ? wdata : m_mem[a];
            e.busy[p] = (m_cnt[a] > (fwd ? 1 : 0));
        end
        e.er  = m_err;
        e.tag = tag;
        q.push_back(e);
    endtask

    // state change at a clock edge, from the driven inputs
    task automatic model_edge();
        int old [DEPTH];
        for (int r = 0; r < DEPTH; r++) old[r] = m_cnt[r];
        if (wen && waddr != 0) m_mem[waddr] = wdata;
        if (flush) begin
            for (int r = 0; r < DEPTH; r++) m_cnt[r] = 0;
            if (iss_en && iss_rd != 0) m_cnt[iss_rd] = 1;
        end else begin
            if (iss_en && iss_rd != 0) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
            if (wen && waddr != 0 && old[waddr] > 0) m_cnt[waddr] = m_cnt[waddr] - 1;
            for (int r = 0; r < DEPTH; r++)
                if (m_cnt[r] > CMAX) begin
                    m_cnt[r] = CMAX;
                    m_err = 1;
                end
        end
    endtask

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic ie, input logic [AW-1:0] ir, input logic fl,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
        wen = we; waddr = wa; wdata = wd;
        iss_en = ie; iss_rd = ir; flush = fl;
        raddr = {a1, a0};
        expect_now(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // monitor: the read side is valid every cycle once stimulus is applied
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("%s.rdata%0d", e.tag, p), rdata[p*DW +: DW], e.rd[p]);
                chk($sformatf("%s.rbusy%0d", e.tag, p), DW'(rbusy[p]), DW'(e.busy[p]));
            end
            chk($sformatf("%s.err", e.tag), DW'(err), DW'(e.er));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH-1));
    endfunction

    initial begin
        rst = 1'b0; raddr = '0; wen = 0; waddr = '0; wdata = '0;
        iss_en = 0; iss_rd = '0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset state of every register on both ports
        for (int r = 0; r < DEPTH; r++)
            step(0, 0, 0, 0, 0, 0, AW'(r), AW'(DEPTH-1-r), "rst_sweep");

        // bypass, then array; r0 ignores writes
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, "byp5");
        step(0, 0, 0, 0, 0, 0, 5, 5, "arr5");
        step(1, 0, 32'h1234, 0, 0, 0, 0, 5, "wr0");
        step(0, 0, 0, 0, 0, 0, 0, 0, "rd0");

        // issue r7, busy until writeback which bypasses
        step(0, 0, 0, 1, 7, 0, 7, 7, "iss7");
        step(0, 0, 0, 0, 0, 0, 7, 7, "busy7a");
        step(0, 0, 0, 0, 0, 0, 7, 7, "busy7b");
        step(1, 7, 32'h55, 0, 0, 0, 7, 7, "wb7");
        step(0, 0, 0, 0, 0, 0, 7, 7, "free7");

        // r3: two issues, then issue+writeback together keeps count at 2
        step(0, 0, 0, 1, 3, 0, 3, 0, "iss3a");
        step(0, 0, 0, 1, 3, 0, 3, 0, "iss3b");
        step(1, 3, 32'hAAA, 1, 3, 0, 3, 3, "isswb3");
        step(0, 0, 0, 0, 0, 0, 3, 3, "hold3");
        step(1, 3, 32'hBBB, 0, 0, 0, 3, 3, "wb3a");
        step(1, 3, 32'hCCC, 0, 0, 0, 3, 3, "wb3b");
        step(1, 3, 32'hDDD, 0, 0, 0, 3, 3, "wb3untracked");
        step(0, 0, 0, 0, 0, 0, 3, 3, "free3");

        // r9: four issues overflow a 2-bit counter
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 9, 0, 9, 0, "iss9");
        step(0, 0, 0, 0, 0, 0, 9, 9, "sat9");
        for (int k = 0; k < 3; k++) step(1, 9, 32'(k + 1), 0, 0, 0, 9, 9, "wb9");
        step(0, 0, 0, 0, 0, 0, 9, 9, "free9");

        // flush drops r4, keeps the r8 issue of the flush cycle
        step(0, 0, 0, 1, 4, 0, 4, 8, "iss4");
        step(0, 0, 0, 1, 8, 0, 4, 8, "iss8");
        step(0, 0, 0, 1, 8, 1, 4, 8, "flush");
        step(0, 0, 0, 0, 0, 0, 4, 8, "postflush");
        step(0, 0, 0, 0, 0, 0, 5, 8, "prereset");

        // asynchronous reset mid-cycle, no clock edge in between
        wen = 0; iss_en = 0; flush = 0; raddr = {AW'(8), AW'(5)};
        #1;
        chk("pre_async.rdata0", rdata[DW-1:0], m_mem[5]);
        rst = 1'b0;
        #1;
        chk("async.rdata0", rdata[DW-1:0], '0);
        chk("async.rbusy", DW'(rbusy), '0);
        chk("async.err", DW'(err), '0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 5, 8, "postreset");

        // randomized traffic
        for (int n = 0; n < 800; n++)
            step(1'($urandom_range(0, 1)), pick(), $urandom,
                 1'($urandom_range(0, 1)), pick(), ($urandom_range(0, 19) == 0),
                 pick(), pick(), "rand");

        wen = 0; iss_en = 0; flush = 0;
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
